// File: rtl/sa_cache_pkg.sv
// Geometry constants, FSM state encoding and address helper for the
// 4-way set-associative write-back data cache.
package sa_cache_pkg;

    localparam int TAG_W  = 18;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 6;
    localparam int WAYS   = 4;
    localparam int SETS   = 256;
    localparam int WORDS  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } state_t;

    function automatic logic [31:0] line_word_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx,
                                                   input logic [3:0]       word);
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Per-set age-based LRU: ages 0 (MRU) .. 3 (LRU) for each way, victim
// selection (first invalid way, else oldest) and MRU promotion.
module sa_cache_lru
    import sa_cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [WAYS-1:0]  set_valid,
    input  logic             touch,
    input  logic [1:0]       touch_way,
    output logic [1:0]       victim
);

    logic [WAYS-1:0][1:0] age_q [SETS];
    logic [WAYS-1:0][1:0] row;
    logic [WAYS-1:0][1:0] row_d;
    logic                 found;

    always_comb begin
        row   = age_q[index];
        row_d = row;
        for (int w = 0; w < WAYS; w++) begin
            if (touch_way == 2'(w)) begin
                row_d[w] = 2'd0;
            end else if (row[w] < row[touch_way]) begin
                row_d[w] = row[w] + 2'd1;
            end
        end
    end

    always_comb begin
        victim = 2'd0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !set_valid[w]) begin
                victim = 2'(w);
                found  = 1'b1;
            end
        end
        // With every way valid the ages form a permutation, so exactly one is 3.
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (row[w] == 2'd3) begin
                    victim = 2'(w);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= 2'(w);
                end
            end
        end else if (touch) begin
            age_q[index] <= row_d;
        end
    end

endmodule

// File: rtl/sa_cache.sv
// 4-way set-associative, write-back, write-allocate data cache with
// word-serial victim write-back and beat-wise refill.
module sa_cache
    import sa_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [31:0]       dataW,
    input  logic              memRW,
    input  logic [31:0]       i_memory_line,
    input  logic              i_memory_response,
    output logic [31:0]       o_data,
    output logic [31:0]       line_data,
    output logic              cache_miss,
    output logic [31:0]       o_evict_data,
    output logic [31:0]       o_evict_addr,
    output logic              o_evict
);

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [WORD_W-1:0] data_mem [SETS][WAYS][WORDS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  victim_q, victim_d;
    logic        cache_miss_q, cache_miss_d;
    logic [31:0] o_data_q, o_data_d;
    logic [31:0] line_data_q, line_data_d;
    logic        evict_q, evict_d;
    logic [31:0] evict_data_q, evict_data_d;
    logic [31:0] evict_addr_q, evict_addr_d;

    logic [WAYS-1:0] match;
    logic            hit;
    logic [1:0]      hit_way;
    logic [3:0]      word;
    logic [1:0]      lru_victim;
    logic            lru_touch;

    logic            data_we;
    logic [1:0]      data_way;
    logic [3:0]      data_word;
    logic [31:0]     data_wdata;
    logic            tag_we;
    logic [WAYS-1:0] valid_row_d;
    logic [WAYS-1:0] dirty_row_d;

    logic unused_offset_bits;
    assign unused_offset_bits = ^i_offset[1:0];
    assign word = i_offset[5:2];

    always_comb begin
        hit_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[i_index][w] && (tag_mem[i_index][w] == i_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way = 2'(w);
            end
        end
        hit = |match;
    end

    sa_cache_lru u_lru (
        .clk       (clk),
        .rst       (rst),
        .index     (i_index),
        .set_valid (valid_q[i_index]),
        .touch     (lru_touch),
        .touch_way (hit_way),
        .victim    (lru_victim)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        victim_d     = victim_q;
        cache_miss_d = cache_miss_q;
        o_data_d     = o_data_q;
        line_data_d  = line_data_q;
        evict_d      = 1'b0;
        evict_data_d = evict_data_q;
        evict_addr_d = evict_addr_q;
        data_we      = 1'b0;
        data_way     = hit_way;
        data_word    = word;
        data_wdata   = dataW;
        tag_we       = 1'b0;
        valid_row_d  = valid_q[i_index];
        dirty_row_d  = dirty_q[i_index];
        lru_touch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    lru_touch = 1'b1;
                    if (memRW) begin
                        data_we              = 1'b1;
                        dirty_row_d[hit_way] = 1'b1;
                        line_data_d          = dataW;
                    end else begin
                        o_data_d    = data_mem[i_index][hit_way][word];
                        line_data_d = data_mem[i_index][hit_way][word];
                    end
                end else begin
                    cache_miss_d = 1'b1;
                    victim_d     = lru_victim;
                    cnt_d        = 4'd0;
                    if (valid_q[i_index][lru_victim] && dirty_q[i_index][lru_victim]) begin
                        state_d = EVICT;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            EVICT: begin
                evict_d      = 1'b1;
                evict_data_d = data_mem[i_index][victim_q][cnt_q];
                evict_addr_d = line_word_addr(tag_mem[i_index][victim_q], i_index, cnt_q);
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                if (i_memory_response) begin
                    data_we    = 1'b1;
                    data_way   = victim_q;
                    data_word  = cnt_q;
                    data_wdata = i_memory_line;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        tag_we                = 1'b1;
                        valid_row_d[victim_q] = 1'b1;
                        dirty_row_d[victim_q] = 1'b0;
                        cache_miss_d          = 1'b0;
                        state_d               = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            victim_q     <= 2'd0;
            cache_miss_q <= 1'b0;
            o_data_q     <= 32'd0;
            line_data_q  <= 32'd0;
            evict_q      <= 1'b0;
            evict_data_q <= 32'd0;
            evict_addr_q <= 32'd0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            victim_q          <= victim_d;
            cache_miss_q      <= cache_miss_d;
            o_data_q          <= o_data_d;
            line_data_q       <= line_data_d;
            evict_q           <= evict_d;
            evict_data_q      <= evict_data_d;
            evict_addr_q      <= evict_addr_d;
            valid_q[i_index]  <= valid_row_d;
            dirty_q[i_index]  <= dirty_row_d;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[i_index][data_way][data_word] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[i_index][victim_q] <= i_tag;
        end
    end

    assign o_data       = o_data_q;
    assign line_data    = line_data_q;
    assign cache_miss   = cache_miss_q;
    assign o_evict      = evict_q;
    assign o_evict_data = evict_data_q;
    assign o_evict_addr = evict_addr_q;

endmodule

// File: tb/tb_sa_cache.sv
// Directed self-checking bench for sa_cache: fills, hits, dirty eviction,
// gapped refill and reset during a refill.
module tb_sa_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] i_tag;
    logic [7:0]  i_index;
    logic [5:0]  i_offset;
    logic [31:0] dataW;
    logic        memRW;
    logic [31:0] i_memory_line;
    logic        i_memory_response;
    logic [31:0] o_data;
    logic [31:0] line_data;
    logic        cache_miss;
    logic [31:0] o_evict_data;
    logic [31:0] o_evict_addr;
    logic        o_evict;

    int n_checks = 0;
    int n_errors = 0;

    logic        r_miss;
    logic        r_held;
    logic        r_done;
    int          r_nev;
    int          r_beats;
    logic [31:0] r_ev_first_d, r_ev_first_a, r_ev_last_d, r_ev_last_a;

    sa_cache dut (
        .clk               (clk),
        .rst               (rst),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_offset          (i_offset),
        .dataW             (dataW),
        .memRW             (memRW),
        .i_memory_line     (i_memory_line),
        .i_memory_response (i_memory_response),
        .o_data            (o_data),
        .line_data         (line_data),
        .cache_miss        (cache_miss),
        .o_evict_data      (o_evict_data),
        .o_evict_addr      (o_evict_addr),
        .o_evict           (o_evict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One core access, including miss handling (write-back observed, refill
    // beats base+k supplied) and the retried access that completes it.
    task automatic do_access(input logic [17:0] tag, input logic [7:0] idx,
                             input logic [5:0] off, input logic rw,
                             input logic [31:0] wd, input logic exp_evict,
                             input logic [31:0] base, input logic gap);
        int k;
        int cyc;
        logic drive;
        i_tag = tag; i_index = idx; i_offset = off; memRW = rw; dataW = wd;
        i_memory_response = 1'b0; i_memory_line = 32'd0;
        @(posedge clk); #1;
        r_miss = cache_miss; r_nev = 0; r_beats = 0; r_held = 1'b1; r_done = 1'b1;
        r_ev_first_d = 32'hX; r_ev_first_a = 32'hX; r_ev_last_d = 32'hX; r_ev_last_a = 32'hX;
        if (cache_miss) begin
            if (exp_evict) begin
                for (int c = 0; c < 40 && r_nev < 16; c++) begin
                    @(posedge clk); #1;
                    if (o_evict) begin
                        if (r_nev == 0) begin
                            r_ev_first_d = o_evict_data; r_ev_first_a = o_evict_addr;
                        end
                        r_ev_last_d = o_evict_data; r_ev_last_a = o_evict_addr;
                        r_nev++;
                    end
                end
            end
            k = 0; cyc = 0;
            while (cache_miss && cyc < 200) begin
                drive = !gap || (cyc % 2 == 0);
                i_memory_response = drive;
                i_memory_line     = base + k;
                @(posedge clk); #1;
                if (drive) k++;
                if (o_evict) r_nev++;
                if (!cache_miss && k < 16) r_held = 1'b0;
                if (cache_miss && k >= 16) r_held = 1'b0;
                cyc++;
            end
            if (cache_miss) r_done = 1'b0;
            i_memory_response = 1'b0;
            r_beats = k;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_tag = '0; i_index = '0; i_offset = '0; dataW = '0; memRW = 1'b0;
        i_memory_line = '0; i_memory_response = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cache_miss", {31'd0, cache_miss}, 32'd0);
        chk("rst_o_evict",    {31'd0, o_evict},    32'd0);
        chk("rst_o_data",     o_data,              32'd0);
        chk("rst_line_data",  line_data,           32'd0);
        rst = 1'b0;

        // Cold read miss, clean fill, retried hit
        do_access(18'd0, 8'd0, 6'd4, 1'b0, 32'd0, 1'b0, 32'h100, 1'b0);
        chk("t1_miss",      {31'd0, r_miss},  32'd1);
        chk("t1_no_evict",  r_nev,            32'd0);
        chk("t1_beats",     r_beats,          32'd16);
        chk("t1_held",      {31'd0, r_held},  32'd1);
        chk("t1_o_data",    o_data,           32'h101);
        chk("t1_line_data", line_data,        32'h101);

        do_access(18'd0, 8'd0, 6'd8, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("t2_miss",   {31'd0, r_miss}, 32'd0);
        chk("t2_o_data", o_data,          32'h102);

        do_access(18'd0, 8'd0, 6'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
        chk("t3_wr_miss",   {31'd0, r_miss}, 32'd0);
        chk("t3_line_data", line_data,       32'hDEADBEEF);
        chk("t3_o_hold",    o_data,          32'h102);
        do_access(18'd0, 8'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("t3_rd_miss",   {31'd0, r_miss}, 32'd0);
        chk("t3_rd_data",   o_data,          32'hDEADBEEF);

        // Fill the remaining ways, then force eviction of the dirty LRU way 0
        for (int t = 1; t <= 3; t++) begin
            do_access(18'(t), 8'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'h1000 * t, 1'b0);
            chk($sformatf("t4_fill%0d_miss", t),  {31'd0, r_miss}, 32'd1);
            chk($sformatf("t4_fill%0d_clean", t), r_nev,           32'd0);
            chk($sformatf("t4_fill%0d_data", t),  o_data,          32'h1000 * t);
        end
        do_access(18'd4, 8'd0, 6'd0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0);
        chk("t4_miss",       {31'd0, r_miss}, 32'd1);
        chk("t4_evict_cnt",  r_nev,           32'd16);
        chk("t4_first_data", r_ev_first_d,    32'hDEADBEEF);
        chk("t4_first_addr", r_ev_first_a,    32'h0000_0000);
        chk("t4_last_data",  r_ev_last_d,     32'h10F);
        chk("t4_last_addr",  r_ev_last_a,     32'h0000_003C);
        chk("t4_beats",      r_beats,         32'd16);
        chk("t4_o_data",     o_data,          32'h400);
        do_access(18'd0, 8'd0, 6'd4, 1'b0, 32'd0, 1'b0, 32'h700, 1'b0);
        chk("t4_tag0_gone",  {31'd0, r_miss}, 32'd1);

        // Refill with a response only every other cycle
        do_access(18'd7, 8'd2, 6'h3C, 1'b0, 32'd0, 1'b0, 32'h500, 1'b1);
        chk("t5_miss",  {31'd0, r_miss}, 32'd1);
        chk("t5_beats", r_beats,         32'd16);
        chk("t5_held",  {31'd0, r_held}, 32'd1);
        chk("t5_done",  {31'd0, r_done}, 32'd1);
        chk("t5_data",  o_data,          32'h50F);

        // Reset in the middle of a refill
        i_tag = 18'd9; i_index = 8'd3; i_offset = 6'd0; memRW = 1'b0;
        @(posedge clk); #1;
        chk("t6_miss", {31'd0, cache_miss}, 32'd1);
        for (int b = 0; b < 5; b++) begin
            i_memory_response = 1'b1; i_memory_line = 32'hBAD0 + b;
            @(posedge clk); #1;
        end
        i_memory_response = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_miss",      {31'd0, cache_miss}, 32'd0);
        chk("t6_rst_o_data",    o_data,              32'd0);
        chk("t6_rst_line_data", line_data,           32'd0);
        do_access(18'd9, 8'd3, 6'd0, 1'b0, 32'd0, 1'b0, 32'h600, 1'b0);
        chk("t6_remiss", {31'd0, r_miss}, 32'd1);
        chk("t6_beats",  r_beats,         32'd16);
        chk("t6_data",   o_data,          32'h600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
